popcnt_accum_mc: RTL and testbench

- Multi-channel successor to the single-stream bit counter/accumulator.
- Counts set bits in each input word through an internal pipelined adder tree and keeps one running sum per channel, so up to CH_CNT fingerprint vectors can arrive word-interleaved.
- On each channel's last word, pushes {channel, sum} into an output FIFO with valid/ready handshake.
- Applies credit-based backpressure so no result is ever lost. Sits between the fingerprint word stream and the Tanimoto score stage.

---
 rtl/popcnt_accum_mc.sv | 245 ++++++++++++++++++++++++
 tb/tb_popcnt_accum_mc.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_accum_mc.sv
// ---------------------------------------------------------------------------
// popcnt_accum_mc -- multi-channel popcount accumulator
//
// Counts the set bits of each accepted word through a registered adder tree
// and keeps one running sum per channel. Words of up to CH_CNT vectors may
// arrive interleaved. The last word of a vector pushes {channel, sum} into an
// output FIFO. A credit check on input acceptance guarantees that every last
// word in flight already owns a FIFO slot.
//
// Optional build macro: POPCNT_ACCUM_SAT_EN
//   defined   : sums saturate at 2^SUM_WIDTH-1, o_SumSat flags a clipped sum
//   undefined : sums wrap modulo 2^SUM_WIDTH, o_SumSat is absent
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   i_Word       input data word
//   i_Chan       channel id of i_Word
//   i_Last       i_Word closes its channel's vector
//   i_Valid      input word valid
//   o_Ready      block accepts a word this cycle
//   o_Sum        completed vector popcount (FIFO head)
//   o_SumChan    channel of o_Sum
//   o_SumSat     head sum was clipped (saturating build only)
//   o_SumValid   FIFO head valid
//   i_SumReady   downstream accepts the head
//   o_ChanErr    sticky: a word with an out-of-range channel was received
// ---------------------------------------------------------------------------
module popcnt_accum_mc #(
    parameter int WORD_WIDTH    = 512,
    parameter int GRANULE_WIDTH = 8,
    parameter int CH_CNT        = 4,
    parameter int SUM_WIDTH     = 16,
    parameter int OUT_DEPTH     = 4,
    localparam int CHW          = (CH_CNT > 1) ? $clog2(CH_CNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] i_Word,
    input  logic [CHW-1:0]        i_Chan,
    input  logic                  i_Last,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    output logic [SUM_WIDTH-1:0]  o_Sum,
    output logic [CHW-1:0]        o_SumChan,
    output logic                  o_SumValid,
`ifdef POPCNT_ACCUM_SAT_EN
    output logic                  o_SumSat,
`endif
    input  logic                  i_SumReady,
    output logic                  o_ChanErr
);

    localparam int NG   = (WORD_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
    localparam int LVLS = $clog2(NG);
    localparam int NP   = 1 << LVLS;
    localparam int PADW = NP * GRANULE_WIDTH;
    localparam int CW   = $clog2(WORD_WIDTH) + 1;
    localparam int GCW  = $clog2(GRANULE_WIDTH) + 1;
    localparam int NCH  = 1 << CHW;
    localparam int AW   = $clog2(OUT_DEPTH);

    function automatic logic [GCW-1:0] granule_pop(input logic [GRANULE_WIDTH-1:0] g);
        logic [GCW-1:0] n;
        n = '0;
        for (int b = 0; b < GRANULE_WIDTH; b++)
            n = n + GCW'(g[b]);
        return n;
    endfunction

    function automatic logic chan_ok(input logic [CHW-1:0] c);
        return 32'(c) < 32'(CH_CNT);
    endfunction

`ifdef POPCNT_ACCUM_SAT_EN
    // Sum with the carry kept so overflow can be detected.
    function automatic logic [SUM_WIDTH:0] add_ext(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [CW-1:0] n);
        return (SUM_WIDTH+1)'(a) + (SUM_WIDTH+1)'(n);
    endfunction

    function automatic logic [SUM_WIDTH-1:0] sat_clip(input logic [SUM_WIDTH:0] s);
        return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
    endfunction
`else
    function automatic logic [SUM_WIDTH-1:0] add_wrap(input logic [SUM_WIDTH-1:0] a,
                                                      input logic [CW-1:0] n);
        return a + SUM_WIDTH'(n);
    endfunction
`endif

    logic [PADW-1:0] word_pad;
    logic            accept;

    logic [CW-1:0]   cnt_p [0:LVLS][0:NP-1];
    logic [CHW-1:0]  chn_p [0:LVLS];
    logic [LVLS:0]   lst_p;
    logic [LVLS:0]   vld_p;

    assign word_pad = PADW'(i_Word);
    assign accept   = i_Valid && o_Ready;

    // Stage 0: per-granule counts. Levels 1..LVLS: one registered tree level each.
    // Entries past the live width of a level carry don't-care sums; the
    // modulo indexing only keeps every reference inside the array.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NP; j++)
            cnt_p[0][j] <= CW'(granule_pop(word_pad[j*GRANULE_WIDTH +: GRANULE_WIDTH]));
        chn_p[0] <= i_Chan;
        lst_p[0] <= i_Last;
        for (int l = 1; l <= LVLS; l++) begin
            for (int j = 0; j < NP; j++)
                cnt_p[l][j] <= cnt_p[l-1][(2*j) % NP] + cnt_p[l-1][(2*j+1) % NP];
            chn_p[l] <= chn_p[l-1];
            lst_p[l] <= lst_p[l-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept;
            for (int l = 1; l <= LVLS; l++)
                vld_p[l] <= vld_p[l-1];
        end
    end

    // Pipe exit: accumulate into the channel's running sum.
    logic [CW-1:0]        x_cnt;
    logic [CHW-1:0]       x_chn;
    logic                 x_lst;
    logic                 x_vld;
    logic                 x_ok;
    logic                 push;
    logic                 pop;

    assign x_cnt = cnt_p[LVLS][0];
    assign x_chn = chn_p[LVLS];
    assign x_lst = lst_p[LVLS];
    assign x_vld = vld_p[LVLS];
    assign x_ok  = chan_ok(x_chn);
    assign push  = x_vld && x_ok && x_lst;

    logic [SUM_WIDTH-1:0] acc [0:NCH-1];
    logic [NCH-1:0]       open;
    logic [SUM_WIDTH-1:0] base;
    logic [SUM_WIDTH-1:0] sum_new;
    logic                 chan_err;
`ifdef POPCNT_ACCUM_SAT_EN
    logic [NCH-1:0]       sat;
    logic [SUM_WIDTH:0]   sum_ext;
    logic                 sat_new;
`endif

    // A closed channel starts from zero, so the accumulator never needs an
    // explicit clear when a vector is pushed.
    always_comb begin
        base = open[x_chn] ? acc[x_chn] : '0;
`ifdef POPCNT_ACCUM_SAT_EN
        sum_ext = add_ext(base, x_cnt);
        sum_new = sat_clip(sum_ext);
        sat_new = (open[x_chn] && sat[x_chn]) || sum_ext[SUM_WIDTH];
`else
        sum_new = add_wrap(base, x_cnt);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++)
                acc[c] <= '0;
            open     <= '0;
            chan_err <= 1'b0;
`ifdef POPCNT_ACCUM_SAT_EN
            sat      <= '0;
`endif
        end else if (x_vld) begin
            if (x_ok) begin
                acc[x_chn]  <= sum_new;
                open[x_chn] <= !x_lst;
`ifdef POPCNT_ACCUM_SAT_EN
                sat[x_chn]  <= x_lst ? 1'b0 : sat_new;
`endif
            end else begin
                chan_err <= 1'b1;
            end
        end
    end

    assign o_ChanErr = chan_err;

    // Output FIFO: pointers carry one wrap bit so full and empty differ.
    logic [SUM_WIDTH-1:0] f_sum [0:OUT_DEPTH-1];
    logic [CHW-1:0]       f_chn [0:OUT_DEPTH-1];
`ifdef POPCNT_ACCUM_SAT_EN
    logic                 f_sat [0:OUT_DEPTH-1];
`endif
    logic [AW:0]          wp;
    logic [AW:0]          rp;
    logic [AW:0]          fifo_cnt;

    assign fifo_cnt   = wp - rp;
    assign o_SumValid = (wp != rp);
    assign pop        = o_SumValid && i_SumReady;
    assign o_Sum      = o_SumValid ? f_sum[rp[AW-1:0]] : '0;
    assign o_SumChan  = o_SumValid ? f_chn[rp[AW-1:0]] : '0;
`ifdef POPCNT_ACCUM_SAT_EN
    assign o_SumSat   = o_SumValid ? f_sat[rp[AW-1:0]] : 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            f_sum[wp[AW-1:0]] <= sum_new;
            f_chn[wp[AW-1:0]] <= x_chn;
`ifdef POPCNT_ACCUM_SAT_EN
            f_sat[wp[AW-1:0]] <= sat_new;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
        end
    end

    // Every last word still in the pipe has a FIFO slot reserved for it.
    int unsigned pend;

    always_comb begin
        pend = '0;
        for (int l = 0; l <= LVLS; l++)
            if (vld_p[l] && lst_p[l] && chan_ok(chn_p[l]))
                pend = pend + 1;
    end

    assign o_Ready = !rst && ((32'(fifo_cnt) + pend) < 32'(OUT_DEPTH));

endmodule

// File: tb/tb_popcnt_accum_mc.sv
module tb_popcnt_accum_mc;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] i_Word;
    logic [1:0]   i_Chan;
    logic         i_Last;
    logic         i_Valid;
    logic         o_Ready;
    logic [15:0]  o_Sum;
    logic [1:0]   o_SumChan;
    logic         o_SumValid;
    logic         i_SumReady;
    logic         o_ChanErr;

    // Second instance: five channels (so id 5 is out of range) and a narrow sum.
    logic [511:0] a_Word;
    logic [2:0]   a_Chan;
    logic         a_Last;
    logic         a_Valid;
    logic         a_Ready;
    logic [9:0]   a_Sum;
    logic [2:0]   a_SumChan;
    logic         a_SumValid;
    logic         a_SumReady;
    logic         a_ChanErr;
`ifdef POPCNT_ACCUM_SAT_EN
    logic         o_SumSat;
    logic         a_SumSat;
`endif

    always #5 clk = ~clk;

    popcnt_accum_mc dut (
        .clk(clk), .rst(rst), .i_Word(i_Word), .i_Chan(i_Chan), .i_Last(i_Last),
        .i_Valid(i_Valid), .o_Ready(o_Ready), .o_Sum(o_Sum), .o_SumChan(o_SumChan),
        .o_SumValid(o_SumValid),
`ifdef POPCNT_ACCUM_SAT_EN
        .o_SumSat(o_SumSat),
`endif
        .i_SumReady(i_SumReady), .o_ChanErr(o_ChanErr)
    );

    popcnt_accum_mc #(.CH_CNT(5), .SUM_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst), .i_Word(a_Word), .i_Chan(a_Chan), .i_Last(a_Last),
        .i_Valid(a_Valid), .o_Ready(a_Ready), .o_Sum(a_Sum), .o_SumChan(a_SumChan),
        .o_SumValid(a_SumValid),
`ifdef POPCNT_ACCUM_SAT_EN
        .o_SumSat(a_SumSat),
`endif
        .i_SumReady(a_SumReady), .o_ChanErr(a_ChanErr)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    bit rnd_ready = 1'b0;

    // Reference model: per-channel running totals, results in completion order.
    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] sum;
    } res_t;

    int unsigned m_sum [4];
    res_t        exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [511:0] w, input logic [1:0] c, input logic l);
        res_t r;
        m_sum[c] = m_sum[c] + $countones(w);
        if (l) begin
            r.ch  = c;
            r.sum = m_sum[c][15:0];
            exp_q.push_back(r);
            m_sum[c] = 0;
        end
    endtask

    function automatic logic [511:0] rnd_word(input int mode);
        logic [511:0] w;
        for (int k = 0; k < 16; k++)
            w[k*32 +: 32] = $urandom;
        case (mode)
            1: w = '1;
            2: w = '0;
            3: begin
                w = '0;
                w[$urandom_range(0, 511)] = 1'b1;
            end
            default: ;
        endcase
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [511:0] w, input logic [1:0] c, input logic l);
        int n;
        n = 0;
        i_Word  = w;
        i_Chan  = c;
        i_Last  = l;
        i_Valid = 1'b1;
        if (rnd_ready) i_SumReady = ($urandom_range(0, 3) != 0);
        while (!o_Ready && n < 200) begin
            @(negedge clk);
            n++;
            if (rnd_ready) i_SumReady = ($urandom_range(0, 3) != 0);
        end
        if (!o_Ready) begin
            chk("send_ready_timeout", o_Ready, 1'b1);
        end else begin
            model_accept(w, c, l);
        end
        @(negedge clk);
        i_Valid = 1'b0;
    endtask

    task automatic a_send(input logic [511:0] w, input logic [2:0] c, input logic l);
        int n;
        n = 0;
        a_Word  = w;
        a_Chan  = c;
        a_Last  = l;
        a_Valid = 1'b1;
        while (!a_Ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_Ready) chk("a_send_ready_timeout", a_Ready, 1'b1);
        @(negedge clk);
        a_Valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!o_SumValid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait_out_valid", o_SumValid, 1'b1);
    endtask

    task automatic a_wait_valid();
        int k;
        k = 0;
        while (!a_SumValid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("a_wait_out_valid", a_SumValid, 1'b1);
    endtask

    // Every head popped from the main instance is checked against the model.
    always @(negedge clk) begin
        res_t r;
        #1;
        if (!rst && o_SumValid && i_SumReady) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got ch=%0d sum=%0d, expected no output", o_SumChan, o_Sum);
            end else begin
                r = exp_q.pop_front();
                chk("out_chan", o_SumChan, r.ch);
                chk("out_sum", o_Sum, r.sum);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [511:0] w;
        logic [1:0]   ch;
        logic [15:0]  exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int k;
        int acc_n;
        int pops0;
        logic [15:0] hold;
        logic [511:0] ones;

        ones = '1;
        tbl[0] = '{w: '1,                ch: 2'd2, exp: 16'd512};
        tbl[1] = '{w: '0,                ch: 2'd3, exp: 16'd0};
        tbl[2] = '{w: {128{4'h5}},       ch: 2'd0, exp: 16'd256};
        tbl[3] = '{w: {1'b1, 511'b0},    ch: 2'd1, exp: 16'd1};
        tbl[4] = '{w: {32{16'h8001}},    ch: 2'd2, exp: 16'd64};
        tbl[5] = '{w: 512'hFFFF_FFFF,    ch: 2'd3, exp: 16'd32};

        for (int c = 0; c < 4; c++) m_sum[c] = 0;
        rst = 1'b1;
        i_Word = '0; i_Chan = '0; i_Last = 1'b0; i_Valid = 1'b0; i_SumReady = 1'b1;
        a_Word = '0; a_Chan = '0; a_Last = 1'b0; a_Valid = 1'b0; a_SumReady = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_ready", o_Ready, 1'b0);
        chk("rst_sumvalid", o_SumValid, 1'b0);
        chk("rst_sum", o_Sum, 16'd0);
        chk("rst_sumchan", o_SumChan, 2'd0);
        chk("rst_chanerr", o_ChanErr, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", o_Ready, 1'b1);
        @(negedge clk);

        // Three all-ones words on channel 0: latency and total.
        send(ones, 2'd0, 1'b0);
        send(ones, 2'd0, 1'b0);
        send(ones, 2'd0, 1'b1);
        wait_valid(k);
        chk("latency_cycles", k, 7);
        chk("ones3_sum", o_Sum, 16'd1536);
        chk("ones3_chan", o_SumChan, 2'd0);
        @(negedge clk);

        // Interleaved channels, back to back.
        send(512'h1, 2'd0, 1'b0);
        send(ones, 2'd1, 1'b0);
        send(512'hFF, 2'd0, 1'b1);
        send(512'h0, 2'd1, 1'b1);
        wait_valid(k);
        chk("ilv_first_chan", o_SumChan, 2'd0);
        chk("ilv_first_sum", o_Sum, 16'd9);
        @(negedge clk);
        chk("ilv_second_valid", o_SumValid, 1'b1);
        chk("ilv_second_chan", o_SumChan, 2'd1);
        chk("ilv_second_sum", o_Sum, 16'd512);
        @(negedge clk);
        chk("ilv_empty", o_SumValid, 1'b0);

        // Table of single-word vectors.
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].w, tbl[i].ch, 1'b1);
            wait_valid(k);
            chk("tbl_chan", o_SumChan, tbl[i].ch);
            chk("tbl_sum", o_Sum, tbl[i].exp);
            @(negedge clk);
        end

        // Backpressure: downstream stalled, continuous single-word vectors.
        i_SumReady = 1'b0;
        acc_n = 0;
        i_Word = rnd_word(0); i_Chan = 2'($urandom_range(0, 3)); i_Last = 1'b1; i_Valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (o_Ready) begin
                model_accept(i_Word, i_Chan, 1'b1);
                acc_n++;
                @(negedge clk);
                i_Word = rnd_word(0);
                i_Chan = 2'($urandom_range(0, 3));
            end else begin
                @(negedge clk);
            end
        end
        chk("bp_accepted", acc_n, 4);
        chk("bp_ready_low", o_Ready, 1'b0);
        chk("bp_head_valid", o_SumValid, 1'b1);
        hold = o_Sum;
        @(negedge clk);
        chk("bp_head_stable", o_Sum, hold);
        i_Valid = 1'b0;
        pops0 = pops;
        i_SumReady = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("bp_drained", pops - pops0, 4);
        chk("bp_empty", o_SumValid, 1'b0);
        chk("bp_ready_back", o_Ready, 1'b1);

        // Narrow sum width: 1536 either saturates or wraps.
        a_send(ones, 3'd0, 1'b0);
        a_send(ones, 3'd0, 1'b0);
        a_send(ones, 3'd0, 1'b1);
        a_wait_valid();
        chk("narrow_chan", a_SumChan, 3'd0);
`ifdef POPCNT_ACCUM_SAT_EN
        chk("narrow_sum_sat", a_Sum, 10'd1023);
        chk("narrow_sat_flag", a_SumSat, 1'b1);
`else
        chk("narrow_sum_wrap", a_Sum, 10'd512);
`endif
        @(negedge clk);
        a_send(512'h7, 3'd0, 1'b1);
        a_wait_valid();
        chk("narrow_next_sum", a_Sum, 10'd3);
`ifdef POPCNT_ACCUM_SAT_EN
        chk("narrow_sat_cleared", a_SumSat, 1'b0);
`endif
        @(negedge clk);

        // Out-of-range channel: dropped, sticky error, neighbours unaffected.
        chk("chanerr_before", a_ChanErr, 1'b0);
        a_send(ones, 3'd5, 1'b1);
        a_send(512'hF, 3'd1, 1'b1);
        a_wait_valid();
        chk("badch_next_chan", a_SumChan, 3'd1);
        chk("badch_next_sum", a_Sum, 10'd4);
        chk("chanerr_set", a_ChanErr, 1'b1);
        @(negedge clk);
        chk("badch_no_push", a_SumValid, 1'b0);

        // Reset mid-vector on channel 2.
        send(ones, 2'd2, 1'b0);
        send(ones, 2'd2, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) m_sum[c] = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("chanerr_cleared", a_ChanErr, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        send(512'h3, 2'd2, 1'b1);
        wait_valid(k);
        chk("rst_fresh_chan", o_SumChan, 2'd2);
        chk("rst_fresh_sum", o_Sum, 16'd2);
        repeat (12) @(negedge clk);
        chk("rst_no_extra", o_SumValid, 1'b0);

        // Randomized traffic with a randomly stalling consumer.
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++)
            send(rnd_word($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        for (int c = 0; c < 4; c++)
            send(rnd_word(0), 2'(c), 1'b1);
        rnd_ready = 1'b0;
        i_SumReady = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rand_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("rand_empty", o_SumValid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
